// File: rtl/pll_lock_manager.sv
// PLL control loop on the reference clock: pulses the PLL reset, retries on lock
// timeout, qualifies lock over a stability window, then releases staged downstream resets.
module pll_lock_manager #(
  parameter int POR_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int NUM_RESETS    = 2,
  parameter int STAGE_GAP     = 16,
  parameter int CNT_W         = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  pll_locked,
  input  logic                  clear_lost,
  output logic                  pll_rst,
  output logic [NUM_RESETS-1:0] sys_rst,
  output logic                  ready,
  output logic                  lock_lost,
  output logic [CNT_W-1:0]      relock_count,
  output logic [CNT_W-1:0]      retry_count
);

  localparam int REL_SPAN = (NUM_RESETS - 1) * STAGE_GAP;
  localparam int MAX_A    = (POR_CYCLES > LOCK_TIMEOUT) ? POR_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B    = (MAX_A > STABLE_CYCLES + 1) ? MAX_A : STABLE_CYCLES + 1;
  localparam int MAX_C    = (MAX_B > REL_SPAN) ? MAX_B : REL_SPAN;
  localparam int CW       = $clog2(MAX_C + 1);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  sync1, lk;
  logic                  pll_rst_n, ready_n, lock_lost_n;
  logic [NUM_RESETS-1:0] sys_rst_n;
  logic [CNT_W-1:0]      relock_n, retry_n;
  int unsigned           elapsed;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state        <= S_PLLRST;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst      <= '1;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      relock_count <= '0;
      retry_count  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      pll_rst      <= pll_rst_n;
      sys_rst      <= sys_rst_n;
      ready        <= ready_n;
      lock_lost    <= lock_lost_n;
      relock_count <= relock_n;
      retry_count  <= retry_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt + CW'(1);
    pll_rst_n   = pll_rst;
    sys_rst_n   = sys_rst;
    ready_n     = ready;
    lock_lost_n = clear_lost ? 1'b0 : lock_lost;
    relock_n    = relock_count;
    retry_n     = retry_count;
    elapsed     = 32'(cnt) + 32'd1;

    case (state)
      S_PLLRST: begin
        if (cnt == CW'(POR_CYCLES - 1)) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (lk) begin
          state_n = S_STABLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_n = S_PLLRST;
          if (retry_count != '1) retry_n = retry_count + CNT_W'(1);
        end
      end
      S_STABLE: begin
        // cnt counts confirmed lk samples; release on the edge after the full window
        if (!lk) begin
          state_n = S_WAIT;
        end else if (cnt == CW'(STABLE_CYCLES)) begin
          sys_rst_n[0] = 1'b0;
          if (NUM_RESETS == 1) begin
            ready_n = 1'b1;
            state_n = S_RUN;
          end else begin
            state_n = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        if (lk) begin
          for (int unsigned i = 1; i < NUM_RESETS; i++) begin
            if (elapsed == i * STAGE_GAP) sys_rst_n[i] = 1'b0;
          end
          if (elapsed == REL_SPAN) begin
            ready_n = 1'b1;
            state_n = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_n = cnt;
      end
      default: begin
        state_n = S_PLLRST;
      end
    endcase

    // lock loss overrides any release progress and any clear request on the same edge
    if ((state == S_RELEASE || state == S_RUN) && !lk) begin
      state_n     = S_PLLRST;
      sys_rst_n   = '1;
      ready_n     = 1'b0;
      lock_lost_n = 1'b1;
      if (relock_count != '1) relock_n = relock_count + CNT_W'(1);
    end

    if (state_n != state) cnt_n = '0;
    pll_rst_n = (state_n == S_PLLRST);
  end

endmodule

// File: tb/tb_pll_lock_manager.sv
// Bench for pll_lock_manager: directed scenarios plus random lock activity, checked
// against a phase/elapsed-time model of the lock manager.
module tb_pll_lock_manager;

  localparam int POR = 4;
  localparam int TMO = 64;
  localparam int STB = 8;
  localparam int NR  = 3;
  localparam int GAP = 4;
  localparam int CW  = 2;

  localparam int P_POR    = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_LIVE   = 3;

  localparam logic [9:0] RESET_VEC = 10'b1_111_0_0_00_00;

  logic          refclk = 1'b0;
  logic          rst = 1'b0;
  logic          pll_locked = 1'b0;
  logic          clear_lost = 1'b0;
  logic          pll_rst;
  logic [NR-1:0] sys_rst;
  logic          ready;
  logic          lock_lost;
  logic [CW-1:0] relock_count;
  logic [CW-1:0] retry_count;
  logic [9:0]    obs;

  int checks = 0;
  int errors = 0;

  always #5 refclk = ~refclk;

  pll_lock_manager #(
    .POR_CYCLES   (POR),
    .LOCK_TIMEOUT (TMO),
    .STABLE_CYCLES(STB),
    .NUM_RESETS   (NR),
    .STAGE_GAP    (GAP),
    .CNT_W        (CW)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .clear_lost  (clear_lost),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .relock_count(relock_count),
    .retry_count (retry_count)
  );

  assign obs = {pll_rst, sys_rst, ready, lock_lost, relock_count, retry_count};

  // Model: current phase, edges elapsed since entering it, and a 2-deep lock history
  typedef struct {
    int          phase;
    int unsigned e;
    int          retry;
    int          relock;
    bit          lost;
    bit          h1;
    bit          h2;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.phase = P_POR; r.e = 0; r.retry = 0; r.relock = 0;
    r.lost = 1'b0; r.h1 = 1'b0; r.h2 = 1'b0;
    return r;
  endfunction

  function automatic model_t model_next(model_t c, bit locked, bit clr);
    model_t n = c;
    bit lk = c.h2;
    bit loss = 1'b0;
    n.h2 = c.h1;
    n.h1 = locked;
    n.e  = c.e + 1;
    case (c.phase)
      P_POR:  if (n.e == POR) begin n.phase = P_WAIT; n.e = 0; end
      P_WAIT: begin
        if (lk) begin
          n.phase = P_STABLE; n.e = 0;
        end else if (n.e == TMO) begin
          n.phase = P_POR; n.e = 0;
          n.retry = (c.retry < 3) ? c.retry + 1 : 3;
        end
      end
      P_STABLE: begin
        if (!lk) begin n.phase = P_WAIT; n.e = 0; end
        else if (n.e == STB + 1) begin n.phase = P_LIVE; n.e = 0; end
      end
      default: begin
        if (!lk) begin
          loss = 1'b1; n.phase = P_POR; n.e = 0;
          n.relock = (c.relock < 3) ? c.relock + 1 : 3;
        end
      end
    endcase
    if (clr) n.lost = 1'b0;
    if (loss) n.lost = 1'b1;
    return n;
  endfunction

  function automatic logic [9:0] model_out(model_t c);
    logic [NR-1:0] s;
    logic          rdy;
    for (int unsigned i = 0; i < NR; i++) s[i] = !(c.phase == P_LIVE && c.e >= i * GAP);
    rdy = (c.phase == P_LIVE) && (c.e >= (NR - 1) * GAP);
    return {c.phase == P_POR, s, rdy, c.lost, 2'(c.relock), 2'(c.retry)};
  endfunction

  always @(posedge refclk or posedge rst) begin
    if (rst) m <= model_reset();
    else     m <= model_next(m, pll_locked, clear_lost);
  end

  always @(negedge refclk) begin
    if (!rst && ready && (sys_rst != '0 || pll_rst)) begin
      errors++;
      $display("FAIL invariant ready=%b sys_rst=%b pll_rst=%b", ready, sys_rst, pll_rst);
    end
  end

  task automatic start(input bit locked);
    rst = 1'b1;
    clear_lost = 1'b0;
    pll_locked = locked;
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    pll_locked = 1'b1;
    @(negedge refclk);
    @(negedge refclk);
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL reset_values dut=%b want=%b", obs, RESET_VEC);
    end
    checks++;
    if (obs !== model_out(m)) begin
      errors++; $display("FAIL reset_model dut=%b want=%b", obs, model_out(m));
    end
  endtask

  task automatic test_release();
    int e_pll = -1;
    int e_rdy = -1;
    int fall[NR];
    for (int i = 0; i < NR; i++) fall[i] = -1;
    start(1'b1);
    for (int n = 1; n <= 30; n++) begin
      @(negedge refclk);
      checks++;
      if (obs !== model_out(m)) begin
        errors++; $display("FAIL release n=%0d dut=%b want=%b", n, obs, model_out(m));
      end
      if (e_pll < 0 && !pll_rst) e_pll = n;
      if (e_rdy < 0 && ready) e_rdy = n;
      for (int i = 0; i < NR; i++) if (fall[i] < 0 && !sys_rst[i]) fall[i] = n;
    end
    checks++;
    if (e_pll != 4) begin errors++; $display("FAIL pll_rst_fall edge=%0d want=4", e_pll); end
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (fall[i] != 14 + i * GAP) begin
        errors++; $display("FAIL sys_rst_fall bit=%0d edge=%0d want=%0d", i, fall[i], 14 + i * GAP);
      end
    end
    checks++;
    if (e_rdy != 22) begin errors++; $display("FAIL ready_rise edge=%0d want=22", e_rdy); end
  endtask

  task automatic test_timeout();
    int rises = 0;
    bit prev = 1'b1;
    start(1'b0);
    for (int n = 1; n <= 280; n++) begin
      @(negedge refclk);
      checks++;
      if (obs !== model_out(m)) begin
        errors++; $display("FAIL timeout n=%0d dut=%b want=%b", n, obs, model_out(m));
      end
      if (pll_rst && !prev) begin
        rises++;
        checks++;
        if (n != 68 * rises) begin
          errors++; $display("FAIL retry_edge k=%0d edge=%0d want=%0d", rises, n, 68 * rises);
        end
        checks++;
        if (retry_count !== 2'((rises < 3) ? rises : 3)) begin
          errors++; $display("FAIL retry_count k=%0d got=%0d want=%0d", rises, retry_count,
                              (rises < 3) ? rises : 3);
        end
      end
      prev = pll_rst;
    end
    checks++;
    if (rises != 4) begin errors++; $display("FAIL retry_pulses got=%0d want=4", rises); end
  endtask

  task automatic test_glitch();
    int f0 = -1;
    start(1'b1);
    for (int n = 1; n <= 30; n++) begin
      @(negedge refclk);
      checks++;
      if (obs !== model_out(m)) begin
        errors++; $display("FAIL glitch n=%0d dut=%b want=%b", n, obs, model_out(m));
      end
      if (f0 < 0 && !sys_rst[0]) f0 = n;
      if (n == 8) pll_locked = 1'b0;
      if (n == 9) pll_locked = 1'b1;
    end
    checks++;
    if (f0 != 21) begin errors++; $display("FAIL glitch_release edge=%0d want=21", f0); end
  endtask

  task automatic test_loss();
    int e_rdy = -1;
    start(1'b1);
    repeat (25) @(negedge refclk);
    pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge refclk);
      checks++;
      if (obs !== model_out(m)) begin
        errors++; $display("FAIL loss k=%0d dut=%b want=%b", k, obs, model_out(m));
      end
      if (k == 2) begin
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL loss_early ready=%b want=1", ready); end
      end
    end
    checks++;
    if ({sys_rst, ready, lock_lost, relock_count} !== {3'b111, 1'b0, 1'b1, 2'd1}) begin
      errors++; $display("FAIL loss_outputs got=%b want=%b",
                         {sys_rst, ready, lock_lost, relock_count}, {3'b111, 1'b0, 1'b1, 2'd1});
    end
    pll_locked = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge refclk);
      checks++;
      if (obs !== model_out(m)) begin
        errors++; $display("FAIL relock n=%0d dut=%b want=%b", n, obs, model_out(m));
      end
      if (e_rdy < 0 && ready) e_rdy = n;
    end
    checks++;
    if (e_rdy != 22) begin errors++; $display("FAIL relock_ready edge=%0d want=22", e_rdy); end
  endtask

  task automatic test_clear_race();
    pll_locked = 1'b0;
    @(negedge refclk);
    @(negedge refclk);
    clear_lost = 1'b1;
    @(negedge refclk);
    clear_lost = 1'b0;
    checks++;
    if ({lock_lost, relock_count} !== {1'b1, 2'd2}) begin
      errors++; $display("FAIL clear_race got=%b want=%b", {lock_lost, relock_count}, {1'b1, 2'd2});
    end
    checks++;
    if (obs !== model_out(m)) begin
      errors++; $display("FAIL clear_race_model dut=%b want=%b", obs, model_out(m));
    end
    pll_locked = 1'b1;
    repeat (3) @(negedge refclk);
    clear_lost = 1'b1;
    @(negedge refclk);
    clear_lost = 1'b0;
    checks++;
    if ({lock_lost, relock_count} !== {1'b0, 2'd2}) begin
      errors++; $display("FAIL clear_lost got=%b want=%b", {lock_lost, relock_count}, {1'b0, 2'd2});
    end
  endtask

  task automatic test_reset_mid();
    int e_pll = -1;
    start(1'b1);
    repeat (15) @(negedge refclk);
    checks++;
    if (sys_rst !== 3'b110) begin errors++; $display("FAIL mid_release sys_rst=%b want=110", sys_rst); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      errors++; $display("FAIL async_reset dut=%b want=%b", obs, RESET_VEC);
    end
    @(negedge refclk);
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge refclk);
      checks++;
      if (obs !== model_out(m)) begin
        errors++; $display("FAIL restart n=%0d dut=%b want=%b", n, obs, model_out(m));
      end
      if (e_pll < 0 && !pll_rst) e_pll = n;
    end
    checks++;
    if (e_pll != 4) begin errors++; $display("FAIL restart_pll_rst edge=%0d want=4", e_pll); end
  endtask

  task automatic test_random();
    int low_hold = 0;
    start(1'b1);
    for (int n = 1; n <= 3000; n++) begin
      @(negedge refclk);
      checks++;
      if (obs !== model_out(m)) begin
        errors++; $display("FAIL random n=%0d dut=%b want=%b", n, obs, model_out(m));
      end
      if (low_hold > 0) begin
        low_hold--;
        pll_locked = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        low_hold = int'($urandom_range(70, 150));
        pll_locked = 1'b0;
      end else if (pll_locked) begin
        pll_locked = ($urandom_range(0, 99) >= 2);
      end else begin
        pll_locked = ($urandom_range(0, 99) < 25);
      end
      clear_lost = ($urandom_range(0, 19) == 0);
    end
    clear_lost = 1'b0;
  endtask

  initial begin
    m = model_reset();
    test_reset();
    test_release();
    test_timeout();
    test_glitch();
    test_loss();
    test_clear_race();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
